// File: rtl/som_pkg.sv
// som_pkg
//   Shared constants and state encoding for the SOM processing system.
//   LANES        : candidates reduced per fetched group
//   DEF_DW/DEF_WW: default distance / weight widths
//   state_t      : 2-bit FSM state with IDLE/FETCH/DONE constants
package som_pkg;

  localparam int LANES  = 8;
  localparam int DEF_DW = 10;
  localparam int DEF_WW = 24;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t DONE  = 2'd2;

endpackage

// File: rtl/bmu_min8.sv
// bmu_min8
//   Combinational 8-way minimum over one fetched group.
//   d_bus    in  8*DW  lane k distance at [k*DW +: DW]
//   w_bus    in  8*WW  lane k weight at [k*WW +: WW]
//   min_d    out DW    smallest distance in the group
//   min_lane out 3     lane that holds it (lowest lane on ties)
//   min_w    out WW    weight of that lane
module bmu_min8
  import som_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int WW = DEF_WW
) (
  input  logic [LANES*DW-1:0] d_bus,
  input  logic [LANES*WW-1:0] w_bus,
  output logic [DW-1:0]       min_d,
  output logic [2:0]          min_lane,
  output logic [WW-1:0]       min_w
);

  // Heap-ordered tree: node n has children 2n+1 / 2n+2, leaves 7..14 hold
  // lanes 0..7, root is node 0. The left child always covers lower lanes, so
  // taking the right child only on a strict less-than gives lowest-lane ties.
  logic [DW-1:0] nd_d [15];
  logic [2:0]    nd_l [15];
  logic [WW-1:0] nd_w [15];

  always_comb begin
    for (int n = 0; n < 15; n++) begin
      nd_d[n] = '0;
      nd_l[n] = '0;
      nd_w[n] = '0;
    end
    for (int k = 0; k < LANES; k++) begin
      nd_d[k+7] = d_bus[k*DW +: DW];
      nd_l[k+7] = 3'(k);
      nd_w[k+7] = w_bus[k*WW +: WW];
    end
    for (int n = 6; n >= 0; n--) begin
      if (nd_d[2*n+2] < nd_d[2*n+1]) begin
        nd_d[n] = nd_d[2*n+2];
        nd_l[n] = nd_l[2*n+2];
        nd_w[n] = nd_w[2*n+2];
      end else begin
        nd_d[n] = nd_d[2*n+1];
        nd_l[n] = nd_l[2*n+1];
        nd_w[n] = nd_w[2*n+1];
      end
    end
  end

  assign min_d    = nd_d[0];
  assign min_lane = nd_l[0];
  assign min_w    = nd_w[0];

endmodule

// File: rtl/bmu_search_ctrl.sv
// bmu_search_ctrl
//   Best-matching-unit search sequencer. Fetches NUM_GROUPS groups of 8
//   candidates, keeps a running minimum and reports the global winner.
//   clk, rst           clock, synchronous active-high reset
//   start       in     begin a search (sampled only in IDLE)
//   busy        out    high in FETCH and DONE
//   grp_req     out    requesting group grp_idx
//   grp_idx     out GW group currently requested
//   grp_valid   in     group data present on d_bus/w_bus
//   d_bus/w_bus in     per-lane distance / weight
//   bmu_valid   out    one-cycle result pulse
//   bmu_dist/bmu_index/bmu_weight out  winner (held until next acceptance)
//
//   state | meaning
//   IDLE  | waiting for start, no request
//   FETCH | requesting groups, folding each accepted group into running min
//   DONE  | result valid for one cycle
module bmu_search_ctrl
  import som_pkg::*;
#(
  parameter int  NUM_GROUPS = 8,
  parameter int  DW         = DEF_DW,
  parameter int  WW         = DEF_WW,
  localparam int GW         = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1,
  localparam int IW         = GW + 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                grp_req,
  output logic [GW-1:0]       grp_idx,
  input  logic                grp_valid,
  input  logic [LANES*DW-1:0] d_bus,
  input  logic [LANES*WW-1:0] w_bus,
  output logic                bmu_valid,
  output logic [DW-1:0]       bmu_dist,
  output logic [IW-1:0]       bmu_index,
  output logic [WW-1:0]       bmu_weight
);

  state_t        state_q, state_d;
  logic [GW-1:0] grp_idx_q, grp_idx_d;
  logic [DW-1:0] dist_q, dist_d;
  logic [IW-1:0] index_q, index_d;
  logic [WW-1:0] weight_q, weight_d;

  logic [DW-1:0] gmin_d;
  logic [2:0]    gmin_lane;
  logic [WW-1:0] gmin_w;

  logic accept;
  logic last_grp;
  logic take;

  bmu_min8 #(
    .DW (DW),
    .WW (WW)
  ) u_min8 (
    .d_bus    (d_bus),
    .w_bus    (w_bus),
    .min_d    (gmin_d),
    .min_lane (gmin_lane),
    .min_w    (gmin_w)
  );

  assign accept   = (state_q == FETCH) && grp_valid;
  assign last_grp = (grp_idx_q == GW'(NUM_GROUPS - 1));
  // First group seeds the running min; later groups must be strictly better
  // so an equal distance in a later group keeps the lower flat index.
  assign take     = accept && ((grp_idx_q == '0) || (gmin_d < dist_q));

  always_comb begin
    state_d   = state_q;
    grp_idx_d = grp_idx_q;
    dist_d    = dist_q;
    index_d   = index_q;
    weight_d  = weight_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          grp_idx_d = '0;
        end
      end
      FETCH: begin
        if (accept) begin
          if (last_grp) begin
            state_d = DONE;
          end else begin
            grp_idx_d = grp_idx_q + GW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take) begin
      dist_d   = gmin_d;
      index_d  = {grp_idx_q, gmin_lane};
      weight_d = gmin_w;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grp_idx_q <= '0;
      dist_q    <= '0;
      index_q   <= '0;
      weight_q  <= '0;
    end else begin
      state_q   <= state_d;
      grp_idx_q <= grp_idx_d;
      dist_q    <= dist_d;
      index_q   <= index_d;
      weight_q  <= weight_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign grp_req    = (state_q == FETCH);
  assign grp_idx    = grp_idx_q;
  assign bmu_valid  = (state_q == DONE);
  assign bmu_dist   = dist_q;
  assign bmu_index  = index_q;
  assign bmu_weight = weight_q;

endmodule

// File: doc/bmu_search_ctrl.md
# bmu_search_ctrl

Best-matching-unit search sequencer for the SOM processing system. Fetches the neuron map in groups of 8 candidates (distance + weight per lane), reduces each group with an 8-way minimum, and keeps a running minimum across groups. After the last group it reports the global winner's distance, flat neuron index and weight with a one-cycle done pulse. Sits between the distance-computation array and the weight-update stage.

## Interface
- NUM_GROUPS, 8, groups of 8 neurons per search (≥1); map size = 8*NUM_GROUPS
- DW, 10, distance width
- WW, 24, weight width (RGB 8+8+8)
- GW, $clog2(NUM_GROUPS) (min 1), group index width
- IW, GW+3, flat neuron index width

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin search; sampled only in IDLE
- busy  out  1  high in FETCH and DONE
- grp_req  out  1  requesting group grp_idx
- grp_idx  out  GW  group currently requested
- grp_valid  in  1  group data present; accepted only when grp_req=1
- d_bus  in  8*DW  lane k distance at [k*DW +: DW]
- w_bus  in  8*WW  lane k weight at [k*WW +: WW]
- bmu_valid  out  1  one-cycle pulse, results valid
- bmu_dist  out  DW  winning distance
- bmu_index  out  IW  winning flat index = grp*8 + lane
- bmu_weight  out  WW  winning weight

## Operation
- States: IDLE, FETCH, DONE.
- IDLE: grp_req=0, busy=0. start=1 → FETCH, grp_idx←0.
- FETCH: grp_req=1. Handshake: a group is accepted on a cycle with grp_req=1 and grp_valid=1; grp_valid=0 stalls indefinitely with grp_idx held. On accept:
  - Group min from bmu_min8: smallest distance; ties → lowest lane.
  - grp_idx=0: running regs load unconditionally.
  - grp_idx>0: replace only if group min < running dist (strict); ties keep earlier group. Net rule: global tie → lowest flat index.
  - grp_idx=NUM_GROUPS-1 → DONE; else grp_idx+1.
- DONE: bmu_valid=1 one cycle, busy=1, grp_req=0 → IDLE.
- start ignored outside IDLE.
- bmu_dist/index/weight are the running registers: meaningful only while bmu_valid=1, but hold their values in IDLE until the first acceptance of the next search.
- Arithmetic: unsigned compares only; index = {grp_idx, lane[2:0]}, no adders.

## Timing
- Reset values: state IDLE, busy 0, grp_req 0, grp_idx 0, bmu_valid 0, bmu_dist 0, bmu_index 0, bmu_weight 0.
- rst in any state, including mid-FETCH, → IDLE next edge. Partial result is discarded. No bmu_valid is emitted.
- start at edge 0 → grp_req=1 from cycle 1.
- With grp_valid held high: groups are accepted at cycles 1..NUM_GROUPS. bmu_valid at cycle NUM_GROUPS+1. IDLE, and start accepted again, at cycle NUM_GROUPS+2.
- Each stall cycle adds exactly one cycle.
- NUM_GROUPS=1: single acceptance → DONE.
- grp_idx never wraps; the counter stops at NUM_GROUPS-1.
- Group reduction is combinational from d_bus/w_bus into the running registers, so grp_valid → register costs no extra latency.

## Structure
- Shared package som_pkg:
  - LANES=8
  - default DW/WW
  - state typedef {IDLE, FETCH, DONE}
- Sub-module bmu_min8: combinational. Inputs d_bus and w_bus. Outputs min distance, 3-bit lane and the selected weight, with the lowest lane winning ties. Tree of 7 comparators, with index and weight carried through the tree; no equality re-search.
- Top-level bmu_search_ctrl holds the FSM, the group counter and the running-minimum registers.

## Test plan
- Reset/idle: rst high 3 cycles → all outputs 0. Then start=0 for 10 cycles → no grp_req, no bmu_valid.
- Basic, NUM_GROUPS=4, grp_valid tied high: group 2 lane 5 = 17, all other distances 500 → bmu_valid at cycle 5, bmu_dist=17, bmu_index=21, bmu_weight=w of group 2 lane 5.
- Ties: group 0 lanes 3 and 6 = 40, group 3 lane 0 = 40, rest 900 → bmu_index=3.
- All-max / backpressure: all distances 1023, grp_valid low 2 cycles before each group → bmu_dist=1023, bmu_index=0, bmu_valid at cycle 13, grp_idx held during each stall.
- Reset mid-operation: rst during grp_idx=2 → IDLE next cycle, no bmu_valid. New start then gives a correct fresh result unaffected by the aborted search.
- Start while busy: start pulses during FETCH and DONE → ignored. Back-to-back start in the first IDLE cycle → second search completes with its own result.
